spi_xfer_ctrl: RTL and testbench
================================

// Module: spi_xfer_ctrl
// PURPOSE
//  Transfer sequencer for the SPI master datapath: accepts one transfer command from the
//  APB register block, drives chip select, configures and gates the SPI clock generator
//  (enable/divider), shifts MOSI and samples MISO on the generator's edge strobes.
//  SPI mode 0 (CPOL=0, CPHA=0), MSB first. Sits between apb_spi regs and clk_gen.
// PARAMETERS
//  DATA_W   32  max bits per transfer; width of tx/rx shift data
//  LEN_W    6   width of xfer_len_i / bit counter (must hold DATA_W)
//  CS_DLY   2   sys-clock cycles of CS setup (before SCLK enable) and hold (after last fall)
// PORTS
//  clk_i          in   1       system clock
//  rst_n_i        in   1       synchronous reset, active low
//  start_i        in   1       transfer request; accepted when start_i && ready_o
//  ready_o        out  1       idle, can accept start_i
//  xfer_len_i     in   LEN_W   bits to transfer, 1..DATA_W; 0 means DATA_W
//  clk_div_cfg_i  in   8       SCLK divider (sys cycles per SCLK period), latched at start
//  tx_data_i      in   DATA_W  transmit word, latched at start; bit [len-1] sent first
//  abort_i        in   1       cancel active transfer
//  done_o         out  1       1-cycle pulse: transfer completed normally
//  rx_data_o      out  DATA_W  received word, right-aligned; valid from done_o until next accept
//  cs_n_o         out  1       chip select, active low
//  mosi_o         out  1       serial data out
//  miso_i         in   1       serial data in
//  clock_en_o     out  1       to clk_gen clock_en_i
//  clk_div_o      out  8       to clk_gen clk_div_i
//  clk_div_vld_o  out  1       to clk_gen clk_div_vld_i
//  rise_edge_i    in   1       from clk_gen: SCLK rises next cycle
//  fall_edge_i    in   1       from clk_gen: SCLK falls next cycle
// BEHAVIOUR
//  Reset (rst_n_i low at posedge): state IDLE; ready_o=1, cs_n_o=1, mosi_o=0, done_o=0,
//   clock_en_o=0, clk_div_vld_o=0, clk_div_o=0, rx_data_o=0, counters 0. Reset mid-transfer
//   returns to these values the next edge; no done_o.
//  FSM: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
//   IDLE : ready_o=1. On accept: latch len (0->DATA_W), div (<2 clamped to 2; odd rounded
//          down), tx word; cs_n_o=0 and mosi_o=tx[len-1] next cycle; go SETUP.
//   SETUP: count CS_DLY cycles, then clock_en_o=1, clk_div_vld_o=1; go XFER.
//   XFER : rise_edge_i -> shift miso_i into rx LSB, bit_cnt+1.
//          fall_edge_i with bit_cnt<len -> mosi_o = next tx bit.
//          fall_edge_i with bit_cnt==len -> clock_en_o=0, clk_div_vld_o=0 next cycle; go HOLD.
//   HOLD : count CS_DLY cycles with cs_n_o=0, then cs_n_o=1, rx_data_o updated, done_o=1
//          for one cycle, mosi_o=0; go IDLE (ready_o=1 same cycle as done_o).
//  Exactly len rising SCLK edges per transfer; SCLK ends low.
//  clk_div_o holds latched divider throughout non-IDLE states; 0 in IDLE.
//  abort_i in SETUP/XFER/HOLD: next cycle clock_en_o=0, clk_div_vld_o=0, cs_n_o=1,
//   mosi_o=0, state IDLE, no done_o, rx_data_o unchanged. abort_i ignored in IDLE.
//  abort_i and start_i same cycle in IDLE: start wins (abort ignored).
//  start_i while not ready_o: ignored, not queued.
//  rise_edge_i/fall_edge_i outside XFER: ignored.
// STRUCTURE
//  Shared package spi_pkg: state enum/localparams (IDLE,SETUP,XFER,HOLD), SPI_DIV_MIN=2.
//  Single module; optional sub-module spi_shift_reg (load, shift-out on fall, shift-in on
//  rise) holding tx/rx shift registers. clk_gen instantiated by the parent, not here.
// TESTING (bench instantiates spi_xfer_ctrl + clk_gen, MISO looped from a model slave)
//  len=8, div=4, tx=0xA5, slave returns 0x3C -> MOSI bits 1010_0101, 8 SCLK rises,
//   rx_data_o=0x3C, done_o one cycle, cs_n_o low for 2+32+2 cycles (approx, exact per RTL).
//  len=0, div=2, tx=0xDEADBEEF, loopback MISO=MOSI -> 32 rises, rx_data_o=0xDEADBEEF.
//  len=1, div=0 (clamped 2) -> exactly one SCLK pulse, rx_data_o[0]=MISO, SCLK ends low.
//  abort_i asserted after 3rd rise of 16-bit xfer -> cs_n_o=1 and clock_en_o=0 next cycle,
//   no done_o, rx_data_o keeps previous value; next start runs a full clean transfer.
//  start_i held high through a transfer + start/abort same cycle in IDLE -> second transfer
//   begins only after done_o; simultaneous start/abort starts transfer.
//  rst_n_i low for 1 cycle mid-XFER -> all outputs at reset values next cycle, ready_o=1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master transfer sequencer.
`timescale 1ns/1ps
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    localparam logic [7:0] SPI_DIV_MIN = 8'd2;

    // SCLK needs an even number of sys cycles, at least two, per period
    function automatic logic [7:0] spi_eff_div(input logic [7:0] div);
        if (div < SPI_DIV_MIN) begin
            return SPI_DIV_MIN;
        end
        return {div[7:1], 1'b0};
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_shift.sv
// TX/RX shift registers: load on accept, shift out on SCLK fall, in on rise.
`timescale 1ns/1ps
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] tx_i,
    input  logic              shift_out_i,
    input  logic              shift_in_i,
    input  logic              miso_i,
    output logic              next_bit_o,
    output logic [DATA_W-1:0] rx_o
);

    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;

    // r_tx holds the bits still to be sent after the one on MOSI
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_tx <= '0;
            r_rx <= '0;
        end else if (load_i) begin
            r_tx <= tx_i;
            r_rx <= '0;
        end else begin
            if (shift_out_i) begin
                r_tx <= {r_tx[DATA_W-2:0], 1'b0};
            end
            if (shift_in_i) begin
                r_rx <= {r_rx[DATA_W-2:0], miso_i};
            end
        end
    end

    assign next_bit_o = r_tx[DATA_W-1];
    assign rx_o       = r_rx;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 transfer sequencer: CS setup, SCLK gating, MSB-first shift, CS hold.
`timescale 1ns/1ps
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6,
    parameter int CS_DLY = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    output logic              ready_o,
    input  logic [LEN_W-1:0]  xfer_len_i,
    input  logic [7:0]        clk_div_cfg_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              abort_i,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              cs_n_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              clock_en_o,
    output logic [7:0]        clk_div_o,
    output logic              clk_div_vld_o,
    input  logic              rise_edge_i,
    input  logic              fall_edge_i
);

    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(DATA_W);
    localparam logic [7:0]       CS_DLY_M1 = 8'(CS_DLY - 1);

    spi_state_e        r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_bit_cnt;
    logic [7:0]        r_dly;
    logic [7:0]        r_div;
    logic              r_cs_n;
    logic              r_mosi;
    logic              r_done;
    logic              r_clk_en;
    logic              r_div_vld;
    logic [DATA_W-1:0] r_rx_data;

    logic              w_accept;
    logic              w_busy_abort;
    logic [LEN_W-1:0]  w_len_eff;
    logic [DATA_W-1:0] w_tx_align;
    logic [DATA_W-1:0] w_tx_rest;
    logic              w_in_xfer;
    logic              w_shift_in;
    logic              w_shift_out;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_rx;

    assign w_accept     = (r_state == ST_IDLE) && start_i;
    assign w_busy_abort = (r_state != ST_IDLE) && abort_i;
    assign w_len_eff    = (xfer_len_i == '0 || xfer_len_i > LEN_MAX)
                          ? LEN_MAX : xfer_len_i;
    // Left-align the word so bit [len-1] sits at the MSB
    assign w_tx_align   = tx_data_i << (LEN_MAX - w_len_eff);
    assign w_tx_rest    = {w_tx_align[DATA_W-2:0], 1'b0};
    assign w_in_xfer    = (r_state == ST_XFER) && !abort_i;
    assign w_shift_in   = w_in_xfer && rise_edge_i;
    assign w_shift_out  = w_in_xfer && fall_edge_i && (r_bit_cnt != r_len);

    spi_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (w_accept),
        .tx_i        (w_tx_rest),
        .shift_out_i (w_shift_out),
        .shift_in_i  (w_shift_in),
        .miso_i      (miso_i),
        .next_bit_o  (w_next_bit),
        .rx_o        (w_rx)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_bit_cnt <= '0;
            r_dly     <= '0;
            r_div     <= '0;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_done    <= 1'b0;
            r_clk_en  <= 1'b0;
            r_div_vld <= 1'b0;
            r_rx_data <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_busy_abort) begin
                r_state   <= ST_IDLE;
                r_cs_n    <= 1'b1;
                r_mosi    <= 1'b0;
                r_clk_en  <= 1'b0;
                r_div_vld <= 1'b0;
                r_div     <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (start_i) begin
                            r_state   <= ST_SETUP;
                            r_len     <= w_len_eff;
                            r_div     <= spi_eff_div(clk_div_cfg_i);
                            r_cs_n    <= 1'b0;
                            r_mosi    <= w_tx_align[DATA_W-1];
                            r_dly     <= '0;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_SETUP: begin
                        if (r_dly == CS_DLY_M1) begin
                            r_clk_en  <= 1'b1;
                            r_div_vld <= 1'b1;
                            r_state   <= ST_XFER;
                        end else begin
                            r_dly <= r_dly + 8'd1;
                        end
                    end
                    ST_XFER: begin
                        if (rise_edge_i) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                        if (fall_edge_i) begin
                            if (r_bit_cnt == r_len) begin
                                r_clk_en  <= 1'b0;
                                r_div_vld <= 1'b0;
                                r_dly     <= '0;
                                r_state   <= ST_HOLD;
                            end else begin
                                r_mosi <= w_next_bit;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (r_dly == CS_DLY_M1) begin
                            r_cs_n    <= 1'b1;
                            r_mosi    <= 1'b0;
                            r_div     <= '0;
                            r_rx_data <= w_rx;
                            r_done    <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_dly <= r_dly + 8'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign ready_o       = (r_state == ST_IDLE);
    assign done_o        = r_done;
    assign rx_data_o     = r_rx_data;
    assign cs_n_o        = r_cs_n;
    assign mosi_o        = r_mosi;
    assign clock_en_o    = r_clk_en;
    assign clk_div_o     = r_div;
    assign clk_div_vld_o = r_div_vld;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl with a behavioural clk_gen, a model slave and a timeline model.
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;
    localparam int CS_DLY = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [LEN_W-1:0]  xfer_len = '0;
    logic [7:0]        div_cfg = '0;
    logic [DATA_W-1:0] tx = '0;
    logic              miso;
    logic              ready, done, cs_n, mosi, clock_en, clk_div_vld;
    logic [DATA_W-1:0] rx_data;
    logic [7:0]        clk_div;

    logic [7:0] gcnt = '0;
    logic       g_rise = 1'b0, g_fall = 1'b0, sclk = 1'b0, sclk_q = 1'b0;

    int          n_rise = 0, n_fall = 0, cs_cnt = 0;
    logic        cs_q = 1'b1;
    logic [31:0] mosi_cap = '0;
    logic        slv_bit;
    logic [31:0] slv_word = '0;
    bit          loop = 1'b0;

    bit          cap_rst = 1'b0, cap_start = 1'b0, cap_abort = 1'b0, cap_loop = 1'b0;
    logic [LEN_W-1:0] cap_len = '0;
    logic [7:0]  cap_div = '0;
    logic [31:0] cap_tx = '0, cap_sw = '0;

    bit          m_act = 1'b0, m_done = 1'b0;
    int          m_len = 0, m_div = 0, m_E = 0, m_L = 0, m_r = 0;
    logic [31:0] m_tx = '0, m_exp_rx = '0, m_rx_out = '0;

    bit          lit_on = 1'b0;
    logic [31:0] lit_rx = '0, lit_mosi = '0;
    int          lit_cs = 0, lit_rise = 0;
    int          tmo = 0;
    bit          fin_req = 1'b0;
    int          tests = 0, fails = 0;

    spi_xfer_ctrl #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .CS_DLY (CS_DLY)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .ready_o       (ready),
        .xfer_len_i    (xfer_len),
        .clk_div_cfg_i (div_cfg),
        .tx_data_i     (tx),
        .abort_i       (abort),
        .done_o        (done),
        .rx_data_o     (rx_data),
        .cs_n_o        (cs_n),
        .mosi_o        (mosi),
        .miso_i        (miso),
        .clock_en_o    (clock_en),
        .clk_div_o     (clk_div),
        .clk_div_vld_o (clk_div_vld),
        .rise_edge_i   (g_rise),
        .fall_edge_i   (g_fall)
    );

    always #5 clk = ~clk;

    // clk_gen stand-in: rise strobe at count 0, fall strobe at half period
    always @(posedge clk) begin
        if (!rst_n || !clock_en) begin
            gcnt   <= '0;
            g_rise <= 1'b0;
            g_fall <= 1'b0;
            sclk   <= 1'b0;
        end else begin
            g_rise <= (gcnt == 8'd0);
            g_fall <= (gcnt == (clk_div >> 1));
            gcnt   <= (gcnt == clk_div - 8'd1) ? 8'd0 : gcnt + 8'd1;
            if (g_rise) sclk <= 1'b1;
            else if (g_fall) sclk <= 1'b0;
        end
    end

    // Model slave: presents next bit after each SCLK fall, records MOSI on rise
    always @(posedge clk) begin
        sclk_q <= sclk;
        if (cs_n) begin
            n_rise   <= 0;
            n_fall   <= 0;
            mosi_cap <= '0;
        end else begin
            if (sclk && !sclk_q) begin
                n_rise   <= n_rise + 1;
                mosi_cap <= {mosi_cap[30:0], mosi};
            end
            if (g_fall && sclk) n_fall <= n_fall + 1;
        end
        if (!cs_n) cs_cnt <= cs_q ? 1 : cs_cnt + 1;
        cs_q <= cs_n;
    end

    always_comb begin
        slv_bit = 1'b0;
        if (n_fall < m_len) slv_bit = slv_word[5'(m_len - 1 - n_fall)];
    end
    assign miso = loop ? mosi : slv_bit;

    always @(posedge clk) begin
        cap_rst   <= rst_n;
        cap_start <= start;
        cap_abort <= abort;
        cap_len   <= xfer_len;
        cap_div   <= div_cfg;
        cap_tx    <= tx;
        cap_sw    <= slv_word;
        cap_loop  <= loop;
    end

    function automatic logic [31:0] lmask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Timeline model and compare, one step per sys clock
    initial begin
        bit was_idle;
        bit en_exp;
        forever begin
            @(negedge clk);
            if (fin_req) begin
                chk("timeouts", 64'(tmo), 64'd0);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
            m_done = 1'b0;
            if (!cap_rst) begin
                m_act    = 1'b0;
                m_rx_out = '0;
            end else begin
                was_idle = !m_act;
                if (m_act) begin
                    m_r++;
                    if (cap_abort) begin
                        m_act = 1'b0;
                    end else if (m_r == m_L) begin
                        m_act    = 1'b0;
                        m_done   = 1'b1;
                        m_rx_out = m_exp_rx;
                    end
                end
                if (was_idle && cap_start) begin
                    m_len    = (cap_len == 0) ? 32 : int'(cap_len);
                    m_div    = (cap_div < 8'd2) ? 2 : (int'(cap_div) / 2) * 2;
                    m_tx     = cap_tx;
                    m_exp_rx = (cap_loop ? cap_tx : cap_sw) & lmask(m_len);
                    m_E      = 2 + (m_len - 1) * m_div + m_div / 2;
                    m_L      = 2 * CS_DLY + m_E;
                    m_r      = 0;
                    m_act    = 1'b1;
                end
            end
            en_exp = m_act && (m_r >= CS_DLY) && (m_r < CS_DLY + m_E);
            chk("ready", 64'(ready), 64'(!m_act));
            chk("cs_n", 64'(cs_n), 64'(!m_act));
            chk("clock_en", 64'(clock_en), 64'(en_exp));
            chk("clk_div_vld", 64'(clk_div_vld), 64'(en_exp));
            chk("clk_div", 64'(clk_div), m_act ? 64'(m_div) : 64'd0);
            chk("done", 64'(done), 64'(m_done));
            chk("rx_data", 64'(rx_data), 64'(m_rx_out));
            if (!m_act) chk("mosi_idle", 64'(mosi), 64'd0);
            if (m_done) begin
                chk("sclk_rises", 64'(n_rise), 64'(m_len));
                chk("mosi_bits", 64'(mosi_cap & lmask(m_len)), 64'(m_tx & lmask(m_len)));
                chk("sclk_low_end", 64'(sclk), 64'd0);
                chk("cs_low_cycles", 64'(cs_cnt), 64'(m_L));
                if (lit_on) begin
                    chk("lit_rx", 64'(rx_data), 64'(lit_rx));
                    chk("lit_mosi", 64'(mosi_cap & lmask(m_len)), 64'(lit_mosi));
                    chk("lit_rises", 64'(n_rise), 64'(lit_rise));
                    chk("lit_cs_dut", 64'(cs_cnt), 64'(lit_cs));
                    chk("lit_cs_model", 64'(m_L), 64'(lit_cs));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_act(input bit v, input int lim);
        int n = 0;
        while (m_act != v && n < lim) begin
            step();
            n++;
        end
        if (m_act != v) tmo++;
    endtask

    task automatic set_in(input int len, input int dv, input logic [31:0] t,
                          input logic [31:0] sw, input bit lp);
        xfer_len = LEN_W'(len);
        div_cfg  = 8'(dv);
        tx       = t;
        slv_word = sw;
        loop     = lp;
    endtask

    task automatic xfer(input int len, input int dv, input logic [31:0] t,
                        input logic [31:0] sw, input bit lp, input int hold, input int ab);
        step();
        set_in(len, dv, t, sw, lp);
        start = 1'b1;
        wait_act(1'b1, 50);
        repeat (hold) step();
        start = 1'b0;
        if (ab > 0) begin
            repeat (ab) step();
            abort = 1'b1;
            step();
            abort = 1'b0;
        end
        wait_act(1'b0, 5000);
    endtask

    initial begin
        int n;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        lit_rx = 32'h3C; lit_mosi = 32'hA5; lit_rise = 8; lit_cs = 36; lit_on = 1'b1;
        xfer(8, 4, 32'hA5, 32'h3C, 1'b0, 0, 0);
        lit_rx = 32'hDEADBEEF; lit_mosi = 32'hDEADBEEF; lit_rise = 32; lit_cs = 69;
        xfer(0, 2, 32'hDEADBEEF, 32'h0, 1'b1, 0, 0);
        lit_rx = 32'h1; lit_mosi = 32'h0; lit_rise = 1; lit_cs = 7;
        xfer(1, 0, 32'hFFFF_FFFE, 32'h1, 1'b0, 0, 0);
        lit_on = 1'b0;

        step();
        set_in(16, 4, 32'h0000_C3A5, 32'h0000_5A5A, 1'b0);
        start = 1'b1;
        wait_act(1'b1, 50);
        start = 1'b0;
        n = 0;
        while (n_rise < 3 && n < 500) begin step(); n++; end
        if (n_rise < 3) tmo++;
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_act(1'b0, 50);
        xfer(16, 6, 32'h0000_1234, 32'h0000_BEEF, 1'b0, 0, 0);

        step();
        set_in(5, 2, 32'h15, 32'h0A, 1'b0);
        start = 1'b1;
        wait_act(1'b1, 50);
        wait_act(1'b0, 500);
        wait_act(1'b1, 5);
        start = 1'b0;
        wait_act(1'b0, 500);

        step();
        set_in(4, 3, 32'h9, 32'h6, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        wait_act(1'b0, 500);

        step();
        set_in(12, 4, 32'hABC, 32'h123, 1'b0);
        start = 1'b1;
        wait_act(1'b1, 50);
        start = 1'b0;
        n = 0;
        while (!(m_act && m_r >= CS_DLY + 6) && n < 200) begin step(); n++; end
        if (!m_act) tmo++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 25; i++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 80)) : 0;
            xfer(int'($urandom_range(0, 32)), int'($urandom_range(0, 11)),
                 $urandom, $urandom, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), ab);
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (4) step();
        fin_req = 1'b1;
        repeat (10) step();
        $display("FAIL final: summary not reached");
        $fatal(1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
